dvp_capture_crop: RTL and testbench

- Second-generation camera pixel capture for the sensor datapath; successor to the fixed 8-to-16-bit pixel reader.
- Samples the DVP bus (pclk, href, vsync, data) as ordinary inputs in the system clock domain and assembles pixels of parametrised byte count.
- Adds a post-configuration frame skip, frame decimation, a per-frame crop window and overflow detection.
- Output feeds the frame-buffer write FIFO.

---
 rtl/dvp_capture_crop.sv | 236 +++++++++++++++++++++++
 tb/tb_dvp_capture_crop.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_crop.sv
// DVP camera capture: oversamples the sensor bus in the system clock domain,
// assembles multi-byte pixels and emits a cropped, decimated pixel stream.
module dvp_capture_crop #(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int CNT_W         = 12,
   parameter int SKIP_FRAMES   = 10,
   parameter int MSB_FIRST     = 1,
   localparam int OUT_W        = DATA_W * BYTES_PER_PIX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pclk,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_href,
   input  logic              i_vsync,
   input  logic              i_en,
   input  logic [CNT_W-1:0]  i_crop_x0,
   input  logic [CNT_W-1:0]  i_crop_y0,
   input  logic [CNT_W-1:0]  i_crop_w,
   input  logic [CNT_W-1:0]  i_crop_h,
   input  logic [3:0]        i_decim,
   input  logic              i_fifo_full,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_data_vld,
   output logic              o_sof,
   output logic              o_eol,
   output logic              o_frame_active,
   output logic              o_overflow,
   output logic [15:0]       o_frame_cnt
);

   localparam int BCW = 3;
   localparam int SKW = 16;
   localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BYTES_PER_PIX - 1);
   localparam logic [BCW-1:0]   BYTE_ONE  = BCW'(1);
   localparam logic [SKW-1:0]   SKIP_LAST = SKW'(SKIP_FRAMES - 1);
   localparam logic [SKW-1:0]   SKIP_ONE  = SKW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W:0]   EXT_ONE   = (CNT_W+1)'(1);

   typedef enum logic [2:0] {IDLE, SKIP, ARM, CAPTURE, DROP} state_t;

   state_t state_q, state_d;

   logic [1:0]        pclk_sync, href_sync, vsync_sync;
   logic [DATA_W-1:0] data_s1, data_s;
   logic              pclk_d, href_d, vsync_d;
   logic              pclk_s, href_s, vsync_s;
   logic              byte_evt, href_rise, href_fall, frame_start, frame_end;

   logic [SKW-1:0]    skip_cnt;
   logic [3:0]        decim_cnt, decim_sh;
   logic [CNT_W-1:0]  x0_sh, y0_sh, w_sh, h_sh;

   logic [BCW-1:0]    byte_cnt, cnt_base, byte_pos;
   logic [OUT_W-1:0]  asm_q, asm_nxt;
   logic              take_byte, pix_done;

   logic [CNT_W-1:0]  x_cnt, y_cnt;
   logic              line_has_pix, sof_pend;
   logic [CNT_W:0]    x_ext, y_ext, x_hi, y_hi;
   logic              in_x, in_y, kept, last_x;

   // All four DVP signals share the same two-flop synchroniser depth so that
   // href, vsync and data stay aligned with the detected pclk edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pclk_sync  <= '0;
         href_sync  <= '0;
         vsync_sync <= '0;
         data_s1    <= '0;
         data_s     <= '0;
         pclk_d     <= 1'b0;
         href_d     <= 1'b0;
         vsync_d    <= 1'b0;
      end else begin
         pclk_sync  <= {pclk_sync[0], i_pclk};
         href_sync  <= {href_sync[0], i_href};
         vsync_sync <= {vsync_sync[0], i_vsync};
         data_s1    <= i_data;
         data_s     <= data_s1;
         pclk_d     <= pclk_sync[1];
         href_d     <= href_sync[1];
         vsync_d    <= vsync_sync[1];
      end
   end

   assign pclk_s      = pclk_sync[1];
   assign href_s      = href_sync[1];
   assign vsync_s     = vsync_sync[1];
   assign byte_evt    = pclk_s & ~pclk_d;
   assign href_rise   = href_s & ~href_d;
   assign href_fall   = ~href_s & href_d;
   assign frame_start = ~vsync_s & vsync_d;
   assign frame_end   = vsync_s & ~vsync_d;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture sequencing: skip the first frames after enable, then pick
   // captured or dropped frames at each frame start via the decimator.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_en && vsync_s) state_d = (SKIP_FRAMES == 0) ? ARM : SKIP;
         SKIP:    if (frame_start && skip_cnt == SKIP_LAST) state_d = ARM;
         ARM:     if (frame_start) state_d = (decim_cnt == 4'd0) ? CAPTURE : DROP;
         CAPTURE: if (frame_end) state_d = ARM;
         DROP:    if (frame_end) state_d = ARM;
         default: state_d = IDLE;
      endcase
      if (!i_en) state_d = IDLE;
   end

   // Byte placement: the first byte of a pixel lands in the top lane when
   // MSB_FIRST is set, otherwise in the bottom lane.
   always_comb begin
      cnt_base  = href_rise ? '0 : byte_cnt;
      byte_pos  = (MSB_FIRST != 0) ? (LAST_BYTE - cnt_base) : cnt_base;
      take_byte = byte_evt && href_s;
      pix_done  = take_byte && (cnt_base == LAST_BYTE);
      asm_nxt   = asm_q;
      for (int b = 0; b < BYTES_PER_PIX; b++) begin
         if (byte_pos == BCW'(b)) asm_nxt[b*DATA_W +: DATA_W] = data_s;
      end
   end

   // Window bounds are evaluated one bit wider so x0+w never wraps.
   always_comb begin
      x_ext  = {1'b0, x_cnt};
      y_ext  = {1'b0, y_cnt};
      x_hi   = {1'b0, x0_sh} + {1'b0, w_sh};
      y_hi   = {1'b0, y0_sh} + {1'b0, h_sh};
      in_x   = (x_cnt >= x0_sh) && (x_ext < x_hi);
      in_y   = (y_cnt >= y0_sh) && (y_ext < y_hi);
      last_x = ((x_ext + EXT_ONE) == x_hi);
      kept   = pix_done && in_x && in_y && (state_q == CAPTURE) && !frame_end;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skip_cnt       <= '0;
         decim_cnt      <= '0;
         decim_sh       <= '0;
         x0_sh          <= '0;
         y0_sh          <= '0;
         w_sh           <= '0;
         h_sh           <= '0;
         byte_cnt       <= '0;
         asm_q          <= '0;
         x_cnt          <= '0;
         y_cnt          <= '0;
         line_has_pix   <= 1'b0;
         sof_pend       <= 1'b0;
         o_data         <= '0;
         o_data_vld     <= 1'b0;
         o_sof          <= 1'b0;
         o_eol          <= 1'b0;
         o_frame_active <= 1'b0;
         o_overflow     <= 1'b0;
         o_frame_cnt    <= '0;
      end else if (!i_en) begin
         skip_cnt       <= '0;
         decim_cnt      <= '0;
         byte_cnt       <= '0;
         asm_q          <= '0;
         x_cnt          <= '0;
         y_cnt          <= '0;
         line_has_pix   <= 1'b0;
         sof_pend       <= 1'b0;
         o_data_vld     <= 1'b0;
         o_sof          <= 1'b0;
         o_eol          <= 1'b0;
         o_frame_active <= 1'b0;
         o_overflow     <= 1'b0;
      end else begin
         o_data_vld     <= 1'b0;
         o_sof          <= 1'b0;
         o_eol          <= 1'b0;
         o_frame_active <= (state_d == CAPTURE);

         if (state_q == IDLE) skip_cnt <= '0;
         else if (state_q == SKIP && frame_start) skip_cnt <= skip_cnt + SKIP_ONE;

         // The decimator advances once per armed frame, using the ratio that
         // was in force when that frame started.
         if (state_q == IDLE) decim_cnt <= '0;
         else if ((state_q == CAPTURE || state_q == DROP) && frame_end)
            decim_cnt <= (decim_cnt >= decim_sh) ? 4'd0 : decim_cnt + 4'd1;

         if (frame_start) begin
            x0_sh    <= i_crop_x0;
            y0_sh    <= i_crop_y0;
            w_sh     <= i_crop_w;
            h_sh     <= i_crop_h;
            decim_sh <= i_decim;
            sof_pend <= 1'b1;
         end

         if (take_byte) begin
            asm_q    <= asm_nxt;
            byte_cnt <= pix_done ? '0 : cnt_base + BYTE_ONE;
         end else if (href_rise || href_fall || frame_start || frame_end) begin
            byte_cnt <= '0;
         end

         if (frame_start || href_fall) x_cnt <= '0;
         else if (pix_done && x_cnt != '1) x_cnt <= x_cnt + CNT_ONE;

         if (frame_start || href_fall) line_has_pix <= 1'b0;
         else if (pix_done) line_has_pix <= 1'b1;

         if (frame_start) y_cnt <= '0;
         else if (href_fall && line_has_pix && y_cnt != '1) y_cnt <= y_cnt + CNT_ONE;

         if (state_q == CAPTURE && frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;

         // A kept pixel that meets a full FIFO is dropped and flagged.
         if (kept) begin
            if (i_fifo_full) begin
               o_overflow <= 1'b1;
            end else begin
               o_data_vld <= 1'b1;
               o_data     <= asm_nxt;
               o_sof      <= sof_pend;
               o_eol      <= last_x;
               sof_pend   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dvp_capture_crop.sv
// Scoreboard bench for dvp_capture_crop: two instances (MSB-first and
// LSB-first) share one DVP stimulus stream; a monitor checks every pixel.
`timescale 1ns/1ps
module tb_dvp_capture_crop;

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_pclk = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_href = 1'b0;
   logic        i_vsync = 1'b0;
   logic        i_en = 1'b0;
   logic [11:0] i_crop_x0 = '0, i_crop_y0 = '0, i_crop_w = '0, i_crop_h = '0;
   logic [3:0]  i_decim = '0;
   logic        i_fifo_full = 1'b0;

   logic [15:0] msb_data, lsb_data, msb_frame_cnt, lsb_frame_cnt;
   logic        msb_vld, msb_sof, msb_eol, msb_active, msb_overflow;
   logic        lsb_vld, lsb_sof, lsb_eol, lsb_active, lsb_overflow;

   logic [11:0] new_x0, new_y0, new_w, new_h;

   exp_t q_msb[$];
   exp_t q_lsb[$];
   exp_t e_msb, e_lsb;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dvp_capture_crop #(.DATA_W(8), .BYTES_PER_PIX(2), .CNT_W(12),
                      .SKIP_FRAMES(2), .MSB_FIRST(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_pclk(i_pclk), .i_data(i_data),
      .i_href(i_href), .i_vsync(i_vsync), .i_en(i_en),
      .i_crop_x0(i_crop_x0), .i_crop_y0(i_crop_y0),
      .i_crop_w(i_crop_w), .i_crop_h(i_crop_h),
      .i_decim(i_decim), .i_fifo_full(i_fifo_full),
      .o_data(msb_data), .o_data_vld(msb_vld), .o_sof(msb_sof),
      .o_eol(msb_eol), .o_frame_active(msb_active),
      .o_overflow(msb_overflow), .o_frame_cnt(msb_frame_cnt)
   );

   dvp_capture_crop #(.DATA_W(8), .BYTES_PER_PIX(2), .CNT_W(12),
                      .SKIP_FRAMES(2), .MSB_FIRST(0)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .i_pclk(i_pclk), .i_data(i_data),
      .i_href(i_href), .i_vsync(i_vsync), .i_en(i_en),
      .i_crop_x0(i_crop_x0), .i_crop_y0(i_crop_y0),
      .i_crop_w(i_crop_w), .i_crop_h(i_crop_h),
      .i_decim(i_decim), .i_fifo_full(i_fifo_full),
      .o_data(lsb_data), .o_data_vld(lsb_vld), .o_sof(lsb_sof),
      .o_eol(lsb_eol), .o_frame_active(lsb_active),
      .o_overflow(lsb_overflow), .o_frame_cnt(lsb_frame_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe from either instance pops its own queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (msb_vld) begin
            if (q_msb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL msb_unexpected_vld: got data %0h, expected no pixel", msb_data);
            end else begin
               e_msb = q_msb.pop_front();
               checkOutput("msb_data", msb_data, e_msb.data);
               checkOutput("msb_sof", msb_sof, e_msb.sof);
               checkOutput("msb_eol", msb_eol, e_msb.eol);
            end
         end
         if (lsb_vld) begin
            if (q_lsb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL lsb_unexpected_vld: got data %0h, expected no pixel", lsb_data);
            end else begin
               e_lsb = q_lsb.pop_front();
               checkOutput("lsb_data", lsb_data, e_lsb.data);
               checkOutput("lsb_sof", lsb_sof, e_lsb.sof);
               checkOutput("lsb_eol", lsb_eol, e_lsb.eol);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_byte(input logic [7:0] d);
      i_data = d;
      i_pclk = 1'b0;
      repeat (4) @(negedge clk);
      i_pclk = 1'b1;
      repeat (4) @(negedge clk);
      i_pclk = 1'b0;
   endtask

   task automatic idle_pclk(input int n);
      for (int i = 0; i < n; i++) begin
         i_pclk = 1'b0;
         repeat (4) @(negedge clk);
         i_pclk = 1'b1;
         repeat (4) @(negedge clk);
         i_pclk = 1'b0;
      end
   endtask

   // One frame: vsync fall, lines of sequential bytes A0,A1,... then vsync rise.
   // The window arguments are the crop the DUT latched at this frame start.
   // mid_action 1 drops i_en after byte 0 of mid_line; 2 loads new_* crop.
   task automatic applyStimulus(input int bytes_per_line, input int lines, input bit capture,
                                input int wx0, input int wy0, input int ww, input int wh,
                                input int full_at, input int mid_line, input int mid_action);
      int         k = 0;
      int         kidx = 0;
      bit         cap = capture;
      bit         first = 1'b1;
      int         x;
      logic [7:0] d, b0;
      exp_t       e;
      b0 = '0;
      i_vsync = 1'b0;
      idle_pclk(2);
      checkOutput("frame_active", msb_active, 32'(cap));
      for (int y = 0; y < lines; y++) begin
         if (y == mid_line && mid_action == 2) begin
            i_crop_x0 = new_x0;
            i_crop_y0 = new_y0;
            i_crop_w  = new_w;
            i_crop_h  = new_h;
         end
         i_href = 1'b1;
         for (int b = 0; b < bytes_per_line; b++) begin
            d = 8'hA0 + 8'(k);
            k++;
            if (b % 2 == 0) begin
               b0 = d;
            end else begin
               x = b / 2;
               if (cap && x >= wx0 && x < wx0 + ww && y >= wy0 && y < wy0 + wh) begin
                  kidx++;
                  if (kidx == full_at) begin
                     i_fifo_full = 1'b1;
                  end else begin
                     e.data = {b0, d};
                     e.sof  = first;
                     e.eol  = (x == wx0 + ww - 1);
                     q_msb.push_back(e);
                     e.data = {d, b0};
                     q_lsb.push_back(e);
                     first = 1'b0;
                  end
               end
            end
            send_byte(d);
            i_fifo_full = 1'b0;
            if (y == mid_line && mid_action == 1 && b == 0) begin
               i_en = 1'b0;
               cap  = 1'b0;
            end
         end
         i_href = 1'b0;
         idle_pclk(2);
      end
      idle_pclk(1);
      i_vsync = 1'b1;
      idle_pclk(3);
   endtask

   task automatic drain();
      repeat (8) @(negedge clk);
      checkOutput("msb_queue_left", q_msb.size(), 0);
      checkOutput("lsb_queue_left", q_lsb.size(), 0);
   endtask

   task automatic set_crop(input int x0, input int y0, input int w, input int h);
      i_crop_x0 = 12'(x0);
      i_crop_y0 = 12'(y0);
      i_crop_w  = 12'(w);
      i_crop_h  = 12'(h);
   endtask

   task automatic reset_dut();
      rst_n   = 1'b0;
      i_en    = 1'b0;
      i_vsync = 1'b0;
      i_href  = 1'b0;
      i_pclk  = 1'b0;
      i_decim = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      new_x0 = '0;
      new_y0 = '0;
      new_w  = '0;
      new_h  = '0;
      reset_dut();
      checkOutput("rst_vld", msb_vld, 0);
      checkOutput("rst_sof", msb_sof, 0);
      checkOutput("rst_eol", msb_eol, 0);
      checkOutput("rst_data", msb_data, 0);
      checkOutput("rst_active", msb_active, 0);
      checkOutput("rst_overflow", msb_overflow, 0);
      checkOutput("rst_frame_cnt", msb_frame_cnt, 0);

      // Two skipped frames, then a full 4x3 window on frame 3.
      set_crop(0, 0, 4, 3);
      i_en = 1'b1;
      i_vsync = 1'b1;
      idle_pclk(3);
      applyStimulus(8, 3, 0, 0, 0, 4, 3, -1, -1, 0);
      applyStimulus(8, 3, 0, 0, 0, 4, 3, -1, -1, 0);
      checkOutput("skip_frame_cnt", msb_frame_cnt, 0);
      applyStimulus(8, 3, 1, 0, 0, 4, 3, -1, -1, 0);
      drain();
      checkOutput("full_frame_cnt", msb_frame_cnt, 1);

      // 2x2 window at (1,1) inside an 8x6 frame.
      set_crop(1, 1, 2, 2);
      applyStimulus(16, 6, 1, 1, 1, 2, 2, -1, -1, 0);
      drain();
      checkOutput("crop_frame_cnt", msb_frame_cnt, 2);

      // Decimation by 3 over six frames after a fresh skip sequence.
      reset_dut();
      set_crop(0, 0, 2, 2);
      i_decim = 4'd2;
      i_en = 1'b1;
      i_vsync = 1'b1;
      idle_pclk(3);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 1, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 1, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      applyStimulus(4, 2, 0, 0, 0, 2, 2, -1, -1, 0);
      drain();
      checkOutput("decim_frame_cnt", msb_frame_cnt, 2);

      // Odd byte count per line: trailing half pixel is discarded.
      i_decim = 4'd0;
      applyStimulus(5, 2, 1, 0, 0, 2, 2, -1, -1, 0);
      drain();
      checkOutput("odd_frame_cnt", msb_frame_cnt, 3);
      checkOutput("odd_overflow", msb_overflow, 0);

      // FIFO full on the third kept pixel.
      set_crop(0, 0, 4, 3);
      applyStimulus(8, 3, 1, 0, 0, 4, 3, 3, -1, 0);
      drain();
      checkOutput("ovf_set", msb_overflow, 1);
      checkOutput("ovf_set_lsb", lsb_overflow, 1);
      checkOutput("ovf_frame_cnt", lsb_frame_cnt, 4);
      idle_pclk(4);
      checkOutput("ovf_held", msb_overflow, 1);

      // Enable dropped on line 1, then re-enabled; crop changes mid-frame.
      applyStimulus(8, 3, 1, 0, 0, 4, 3, -1, 1, 1);
      drain();
      checkOutput("ovf_cleared", msb_overflow, 0);
      checkOutput("ovf_cleared_lsb", lsb_overflow, 0);
      checkOutput("drop_active", msb_active, 0);
      new_x0 = 12'd1;
      new_y0 = 12'd0;
      new_w  = 12'd2;
      new_h  = 12'd3;
      i_en = 1'b1;
      idle_pclk(2);
      applyStimulus(8, 3, 0, 0, 0, 4, 3, -1, -1, 0);
      applyStimulus(8, 3, 0, 0, 0, 4, 3, -1, -1, 0);
      applyStimulus(8, 3, 1, 0, 0, 4, 3, -1, 1, 2);
      drain();
      applyStimulus(8, 3, 1, 1, 0, 2, 3, -1, -1, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
